// File: rtl/click_control_pkg.sv
// Shared types and constants for the two-phase Click pipeline controller.
// Consumed by click_control and click_sync.
package click_control_pkg;

    typedef logic phase_t;

    localparam int     SYNC_STAGES = 2;
    localparam phase_t PHASE_RESET = 1'b0;

endpackage

// File: rtl/click_sync.sv
// N-stage flop synchronizer with synchronous active-high reset.
// Used on the handshake inputs when CLICK_CONTROL_SYNC_EN is defined.
module click_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [N-1:0] stage_q;
    logic [N-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q << 1;
        stage_d[0] = d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[N-1];

endmodule

// File: rtl/click_control.sv
// Two-phase Click controller: forwards channel-A tokens to channel B.
// Define CLICK_CONTROL_SYNC_EN to synchronize aReq/bAck before use.
module click_control
    import click_control_pkg::*;
#(
    parameter int ff_width = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                aReq,
    input  logic                bAck,
    output logic [ff_width-1:0] aAck,
    output logic [ff_width-1:0] bReq,
    output logic                fire
);

    logic aReq_s;
    logic bAck_s;

`ifdef CLICK_CONTROL_SYNC_EN
    click_sync #(
        .N (SYNC_STAGES)
    ) u_sync_a (
        .clk   (clk),
        .reset (reset),
        .d     (aReq),
        .q     (aReq_s)
    );

    click_sync #(
        .N (SYNC_STAGES)
    ) u_sync_b (
        .clk   (clk),
        .reset (reset),
        .d     (bAck),
        .q     (bAck_s)
    );
`else
    assign aReq_s = aReq;
    assign bAck_s = bAck;
`endif

    phase_t phase_q;
    phase_t phase_d;
    logic   fire_q;
    logic   fire_d;

    // Pending token on A and B has consumed the previous one.
    always_comb begin
        fire_d  = (aReq_s != phase_q) && (bAck_s == phase_q);
        phase_d = phase_q ^ fire_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PHASE_RESET;
            fire_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            fire_q  <= fire_d;
        end
    end

    assign aAck = {ff_width{phase_q}};
    assign bReq = {ff_width{phase_q}};
    assign fire = fire_q;

endmodule

// File: tb/tb_click_control.sv
// Self-checking bench for click_control: directed table plus random run
// against a token-counting reference model.
module tb_click_control;

`ifdef CLICK_CONTROL_SYNC_EN
    localparam int W = 4;
    localparam int D = 2;
`else
    localparam int W = 1;
    localparam int D = 0;
`endif
    localparam int LAT = D + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         aReq;
    logic         bAck;
    logic [W-1:0] aAck;
    logic [W-1:0] bReq;
    logic         fire;

    int errors = 0;
    int checks = 0;

    click_control #(
        .ff_width (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .aReq  (aReq),
        .bAck  (bAck),
        .aAck  (aAck),
        .bReq  (bReq),
        .fire  (fire)
    );

    always #5 clk = ~clk;

    // Reference model: counts transfers; the controller's phase is the
    // parity of transfers since reset. Inputs are seen D edges late.
    int   n_fired;
    logic m_fire;
    logic h_a [0:D];
    logic h_b [0:D];

    task automatic model_edge();
        logic ua;
        logic ub;
        if (reset) begin
            n_fired = 0;
            m_fire  = 1'b0;
            for (int i = 0; i <= D; i++) begin
                h_a[i] = 1'b0;
                h_b[i] = 1'b0;
            end
        end else begin
            for (int i = D; i > 0; i--) begin
                h_a[i] = h_a[i-1];
                h_b[i] = h_b[i-1];
            end
            h_a[0] = aReq;
            h_b[0] = bAck;
            ua = h_a[D];
            ub = h_b[D];
            m_fire = (ua != n_fired[0]) && (ub == n_fired[0]);
            if (m_fire) n_fired++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check(string name, logic exp_ph, logic exp_fire);
        logic [W-1:0] exp_v;
        exp_v = {W{exp_ph}};
        checks++;
        if (aAck !== exp_v || bReq !== exp_v || fire !== exp_fire) begin
            errors++;
            $display("FAIL %s: aAck=%h bReq=%h fire=%b, required aAck=%h bReq=%h fire=%b",
                     name, aAck, bReq, fire, exp_v, exp_v, exp_fire);
        end
    endtask

    typedef struct {
        string name;
        logic  rst;
        logic  a;
        logic  b;
        logic  ph;
        logic  f;
    } vec_t;

    vec_t tbl[$];
    int   n_fire_dut;
    int   n_fire_ref;

    initial begin
        tbl.push_back('{"reset_a1_0",      1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{"reset_a1_1",      1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{"idle",            1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{"single_token",    1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{"no_refire",       1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{"simultaneous",    1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{"back_low_nofire", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{"token2",          1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{"blocked_0",       1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{"blocked_1",       1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{"unblock",         1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{"b_busy_idle",     1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{"b_return",        1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{"token3",          1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{"pending",         1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{"mid_reset",       1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{"post_reset",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{"fresh_token",     1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{"reset_priority",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{"release",         1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        reset = 1'b1;
        aReq  = 1'b0;
        bAck  = 1'b0;
        tick();
        tick();

        // Each row is held LAT edges so the same table fits both builds.
        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            aReq  = tbl[i].a;
            bAck  = tbl[i].b;
            for (int k = 0; k < LAT; k++) tick();
            check(tbl[i].name, tbl[i].ph, tbl[i].f);
        end

        // Fire must be a single-cycle pulse exactly LAT edges after aReq.
        reset = 1'b0;
        aReq  = 1'b1;
        for (int k = 1; k < LAT; k++) begin
            tick();
            check("latency_wait", 1'b0, 1'b0);
        end
        tick();
        check("latency_fire", 1'b1, 1'b1);
        tick();
        check("pulse_width", 1'b1, 1'b0);

        reset = 1'b1;
        aReq  = 1'b0;
        bAck  = 1'b0;
        for (int k = 0; k < LAT; k++) tick();
        reset = 1'b0;

        // Random handshakes, with partners that toggle at will.
        n_fire_dut = 0;
        n_fire_ref = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 63) == 0) begin
                reset = 1'b1;
                aReq  = 1'b0;
                bAck  = 1'b0;
            end else begin
                reset = 1'b0;
                if ($urandom_range(0, 2) == 0) aReq = ~aReq;
                if ($urandom_range(0, 2) == 0) bAck = ~bAck;
            end
            tick();
            check("random", n_fired[0], m_fire);
            n_fire_dut += int'(fire);
            n_fire_ref += int'(m_fire);
        end

        checks++;
        if (n_fire_dut != n_fire_ref) begin
            errors++;
            $display("FAIL fire_count: got %0d pulses, required %0d",
                     n_fire_dut, n_fire_ref);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
